rf_write_arbiter: RTL and testbench

//  Shares the register file's WRITE_PORTS write ports among NUM_REQ writeback requesters (ALU, LSU, MUL, ...).

---
 rtl/rf_write_arbiter_pkg.sv | 19 +
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter_pick.sv | 69 ++++++
 rtl/rf_write_arbiter.sv | 74 +++++++
 tb/tb_rf_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults, write-port payload type and sizing helper for the
// register-file write arbiter.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_NUM_REGS   = 32;
    localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } rf_wr_t;

    // Index width that stays >= 1 even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side bus plus RF write-port bus of the write arbiter.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WRITE_PORTS = 1,
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH
) ();

    logic [NUM_REQ-1:0]                         req_valid;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]         req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         req_data;
    logic [NUM_REQ-1:0]                         req_ready;
    logic                                       hold;
    logic [WRITE_PORTS-1:0]                     write_reg_enable;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]     write_addrs;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]     write_data;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, write_reg_enable, write_addrs, write_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, write_reg_enable, write_addrs, write_data
    );

endinterface

// File: rtl/rf_write_arbiter_pick.sv
// Combinational round-robin picker: grants up to WRITE_PORTS valid requests
// starting at i_rr_ptr, skipping requests whose nonzero address is already granted.
module rr_multi_pick
    import rf_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WRITE_PORTS = 1,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
    localparam int IDX_W      = idx_width(NUM_REQ),
    localparam int CNT_W      = $clog2(WRITE_PORTS + 1)
) (
    input  logic [NUM_REQ-1:0]                  i_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  i_addr,
    input  logic [IDX_W-1:0]                    i_rr_ptr,
    output logic [NUM_REQ-1:0]                  o_grant,
    output logic [WRITE_PORTS-1:0]              o_port_valid,
    output logic [WRITE_PORTS-1:0][IDX_W-1:0]   o_port_src,
    output logic                                o_any,
    output logic [IDX_W-1:0]                    o_next_ptr
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] last;
        logic [CNT_W-1:0] n_grant;
        logic             clash;

        o_grant      = '0;
        o_port_valid = '0;
        o_port_src   = '0;
        sum          = '0;
        idx          = '0;
        last         = '0;
        n_grant      = '0;
        clash        = 1'b0;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ))
                sum = sum - (IDX_W+1)'(NUM_REQ);
            idx = sum[IDX_W-1:0];

            // x0 never conflicts: its enable is masked downstream anyway.
            clash = 1'b0;
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                if (CNT_W'(p) < n_grant && i_addr[idx] != '0 &&
                    i_addr[o_port_src[p]] == i_addr[idx])
                    clash = 1'b1;
            end

            if (i_valid[idx] && n_grant < CNT_W'(WRITE_PORTS) && !clash) begin
                o_grant[idx] = 1'b1;
                for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                    if (CNT_W'(p) == n_grant) begin
                        o_port_valid[p] = 1'b1;
                        o_port_src[p]   = idx;
                    end
                end
                last    = idx;
                n_grant = n_grant + CNT_W'(1);
            end
        end

        o_any      = (n_grant != '0);
        o_next_ptr = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + IDX_W'(1);
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write ports among writeback requesters: round-robin grant,
// registered write ports, x0 writes granted but never enabled.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int NUM_REGS    = RF_NUM_REGS,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int NUM_REQ     = 4,
    parameter int WRITE_PORTS = 1
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]                     w_valid;
    logic [NUM_REQ-1:0]                     w_grant;
    logic [WRITE_PORTS-1:0]                 w_port_valid;
    logic [WRITE_PORTS-1:0][IDX_W-1:0]      w_port_src;
    logic                                   w_any;
    logic [IDX_W-1:0]                       w_next_ptr;

    logic [IDX_W-1:0]                       r_rr_ptr;
    logic [WRITE_PORTS-1:0]                 r_wr_en;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] r_wr_addr;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] r_wr_data;

    // Gating valids before the picker keeps ready low under reset/hold.
    assign w_valid = (rst || bus.hold) ? '0 : bus.req_valid;

    rr_multi_pick #(
        .NUM_REQ     (NUM_REQ),
        .WRITE_PORTS (WRITE_PORTS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_pick (
        .i_valid      (w_valid),
        .i_addr       (bus.req_addr),
        .i_rr_ptr     (r_rr_ptr),
        .o_grant      (w_grant),
        .o_port_valid (w_port_valid),
        .o_port_src   (w_port_src),
        .o_any        (w_any),
        .o_next_ptr   (w_next_ptr)
    );

    assign bus.req_ready = w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                r_wr_en[p] <= w_port_valid[p] && (bus.req_addr[w_port_src[p]] != '0);
                if (w_port_valid[p]) begin
                    r_wr_addr[p] <= bus.req_addr[w_port_src[p]];
                    r_wr_data[p] <= bus.req_data[w_port_src[p]];
                end
            end
            if (w_any)
                r_rr_ptr <= w_next_ptr;
        end
    end

    assign bus.write_reg_enable = r_wr_en;
    assign bus.write_addrs      = r_wr_addr;
    assign bus.write_data       = r_wr_data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Drives a 1-port and a 2-port arbiter side by side and checks both against
// a queue-free rotation/grant model plus directed scenarios.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    rf_write_arbiter_if #(.NUM_REQ(NR), .WRITE_PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
    rf_write_arbiter_if #(.NUM_REQ(NR), .WRITE_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();

    rf_write_arbiter #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_REQ(NR), .WRITE_PORTS(1)) u_wp1 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    rf_write_arbiter #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_REQ(NR), .WRITE_PORTS(2)) u_wp2 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Stimulus per DUT (index 0: one port, index 1: two ports)
    logic [NR-1:0] s_valid [2];
    rf_wr_t        s_req   [2][NR];
    logic          s_hold;

    // Reference model state
    int            m_ptr   [2];
    int            m_n     [2];
    int            m_src   [2][2];
    logic [NR-1:0] m_ready [2];
    logic [1:0]    m_en    [2];
    rf_wr_t        m_out   [2][2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_eval(input int d);
        int  i;
        bit  clash;
        m_ready[d] = '0;
        m_n[d]     = 0;
        if (rst || s_hold) return;
        for (int k = 0; k < NR; k++) begin
            i = (m_ptr[d] + k) % NR;
            if (!s_valid[d][i] || m_n[d] == d + 1) continue;
            clash = 0;
            for (int j = 0; j < m_n[d]; j++)
                if (s_req[d][i].addr != 0 && s_req[d][m_src[d][j]].addr == s_req[d][i].addr)
                    clash = 1;
            if (clash) continue;
            m_src[d][m_n[d]] = i;
            m_ready[d][i]    = 1'b1;
            m_n[d]++;
        end
    endfunction

    function automatic void model_commit(input int d);
        m_en[d] = '0;
        if (rst) begin
            m_ptr[d] = 0;
            return;
        end
        for (int j = 0; j < m_n[d]; j++) begin
            m_en[d][j]  = (s_req[d][m_src[d][j]].addr != 0);
            m_out[d][j] = s_req[d][m_src[d][j]];
        end
        if (m_n[d] > 0) m_ptr[d] = (m_src[d][m_n[d]-1] + 1) % NR;
    endfunction

    task automatic drive();
        bus0.req_valid = s_valid[0];
        bus1.req_valid = s_valid[1];
        for (int i = 0; i < NR; i++) begin
            bus0.req_addr[i] = s_req[0][i].addr;
            bus0.req_data[i] = s_req[0][i].data;
            bus1.req_addr[i] = s_req[1][i].addr;
            bus1.req_data[i] = s_req[1][i].data;
        end
        bus0.hold = s_hold;
        bus1.hold = s_hold;
    endtask

    // Apply inputs mid-cycle and check the combinational ready vectors.
    task automatic settle();
        drive();
        #1;
        model_eval(0);
        model_eval(1);
        check("ready_wp1", 32'(bus0.req_ready), 32'(m_ready[0]));
        check("ready_wp2", 32'(bus1.req_ready), 32'(m_ready[1]));
    endtask

    // Clock edge, then check registered write ports and retire granted requests.
    task automatic edge_step();
        @(posedge clk);
        model_commit(0);
        model_commit(1);
        #1;
        check("en_wp1", 32'(bus0.write_reg_enable[0]), 32'(m_en[0][0]));
        if (m_en[0][0]) begin
            check("addr_wp1", 32'(bus0.write_addrs[0]), 32'(m_out[0][0].addr));
            check("data_wp1", bus0.write_data[0], m_out[0][0].data);
        end
        for (int p = 0; p < 2; p++) begin
            check($sformatf("en_wp2_p%0d", p), 32'(bus1.write_reg_enable[p]), 32'(m_en[1][p]));
            if (m_en[1][p]) begin
                check($sformatf("addr_wp2_p%0d", p), 32'(bus1.write_addrs[p]), 32'(m_out[1][p].addr));
                check($sformatf("data_wp2_p%0d", p), bus1.write_data[p], m_out[1][p].data);
            end
        end
        if (bus1.write_reg_enable == 2'b11)
            check("dup_addr_wp2", 32'(bus1.write_addrs[0] != bus1.write_addrs[1]), 32'd1);
        for (int d = 0; d < 2; d++)
            s_valid[d] = s_valid[d] & ~m_ready[d];
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        s_hold = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = '1;
            m_ptr[d]   = 0;
            m_n[d]     = 0;
            m_en[d]    = '0;
            for (int i = 0; i < NR; i++) begin
                s_req[d][i].addr = 5'(i + 1);
                s_req[d][i].data = $urandom();
            end
        end
        @(negedge clk);

        // 1. Reset with all requesters valid
        for (int c = 0; c < 2; c++) begin
            s_valid[0] = '1;
            s_valid[1] = '1;
            settle();
            check("rst_ready_wp1", 32'(bus0.req_ready), 32'd0);
            edge_step();
        end
        check("rst_addr_wp1", 32'(bus0.write_addrs[0]), 32'd0);
        check("rst_data_wp1", bus0.write_data[0], 32'd0);
        check("rst_addr_wp2", 32'(bus1.write_addrs), 32'd0);
        check("rst_data_wp2_p1", bus1.write_data[1], 32'd0);
        rst        = 1'b0;
        s_valid[0] = '0;
        s_valid[1] = '0;

        // 2. Single write on the one-port arbiter
        s_valid[0][0]    = 1'b1;
        s_req[0][0].addr = 5'd5;
        s_req[0][0].data = 32'hDEADBEEF;
        settle();
        check("single_ready", 32'(bus0.req_ready), 32'b0001);
        edge_step();
        check("single_en", 32'(bus0.write_reg_enable), 32'd1);
        check("single_addr", 32'(bus0.write_addrs[0]), 32'd5);
        check("single_data", bus0.write_data[0], 32'hDEADBEEF);

        // 3. Round-robin from a fresh pointer, all four held valid
        rst = 1'b1;
        settle();
        edge_step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NR; i++) begin
                s_valid[0][i]    = 1'b1;
                s_req[0][i].addr = 5'(i + 1);
                if (c > 0 && !s_valid[0][i]) s_req[0][i].data = $urandom();
            end
            settle();
            check($sformatf("rr_order_c%0d", c), 32'(bus0.req_ready), 32'(1) << (c % NR));
            edge_step();
        end
        s_valid[0] = '0;

        // 4. Same-address conflict on the two-port arbiter, rr_ptr brought to 1
        s_valid[1][0]    = 1'b1;
        s_req[1][0].addr = 5'd9;
        settle();
        edge_step();
        s_valid[1]       = 4'b0110;
        s_req[1][1]      = '{addr: 5'd7, data: 32'hAAAA0001};
        s_req[1][2]      = '{addr: 5'd7, data: 32'hBBBB0002};
        settle();
        check("conflict_ready_t", 32'(bus1.req_ready), 32'b0010);
        edge_step();
        check("conflict_en_t", 32'(bus1.write_reg_enable), 32'b01);
        settle();
        check("conflict_ready_t1", 32'(bus1.req_ready), 32'b0100);
        edge_step();
        check("conflict_data_t1", bus1.write_data[0], 32'hBBBB0002);

        // 5. x0 write: granted, never enabled, pointer wraps to 0
        s_valid[0][3]    = 1'b1;
        s_req[0][3]      = '{addr: 5'd0, data: 32'h55};
        settle();
        check("x0_ready", 32'(bus0.req_ready), 32'b1000);
        edge_step();
        check("x0_en", 32'(bus0.write_reg_enable), 32'd0);
        s_valid[0] = '1;
        for (int i = 0; i < NR; i++) s_req[0][i].addr = 5'(i + 1);
        settle();
        check("x0_ptr_wrap", 32'(bus0.req_ready), 32'b0001);
        edge_step();
        s_valid[0] = '0;

        // 6. hold freezes grants and pointer; reset drops pending writes
        s_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_valid[0][2] = 1'b1;
            s_valid[1][2] = 1'b1;
            settle();
            check("hold_ready_wp1", 32'(bus0.req_ready), 32'd0);
            check("hold_ready_wp2", 32'(bus1.req_ready), 32'd0);
            edge_step();
        end
        s_hold = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = '1;
            for (int i = 0; i < NR; i++) s_req[d][i].addr = 5'(i + 10);
        end
        settle();
        check("hold_resume_wp1", 32'(bus0.req_ready), 32'b0010);
        check("hold_resume_wp2", 32'(bus1.req_ready), 32'b1001);
        edge_step();
        check("hold_prev_en", 32'(bus0.write_reg_enable), 32'd1);
        s_hold = 1'b1;
        settle();
        edge_step();
        check("hold_drain_wp1", 32'(bus0.write_reg_enable), 32'd0);
        check("hold_drain_wp2", 32'(bus1.write_reg_enable), 32'd0);
        s_hold = 1'b0;
        settle();
        check("pre_rst_ready", 32'(bus0.req_ready), 32'b0100);
        edge_step();
        check("pre_rst_en", 32'(bus0.write_reg_enable), 32'd1);
        rst = 1'b1;
        settle();
        check("mid_rst_ready", 32'(bus0.req_ready), 32'd0);
        edge_step();
        check("mid_rst_en_wp1", 32'(bus0.write_reg_enable), 32'd0);
        check("mid_rst_en_wp2", 32'(bus1.write_reg_enable), 32'd0);
        rst = 1'b0;

        // Randomized traffic: small address space to provoke conflicts and x0
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(59) == 0);
            s_hold = ($urandom_range(7) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NR; i++) begin
                    if (!s_valid[d][i] && $urandom_range(9) < 6) begin
                        s_valid[d][i]    = 1'b1;
                        s_req[d][i].addr = 5'($urandom_range(7));
                        s_req[d][i].data = $urandom();
                    end
                end
            end
            settle();
            edge_step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
